fetch_unit: RTL and testbench

Instruction-fetch stage for the pipelined core. Owns the PC, issues 16-bit instruction reads to a variable-latency instruction memory, and presents fetched instructions to the IF/ID register. The branch controller steers it through `IF_rewrite_pc` / `IF_pc_rewrite_to`. Wrong-path instructions are flushed, including in-flight memory responses. At most one memory request is outstanding. A one-entry pending buffer absorbs a response that returns while decode is stalled.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Holds the PC and issues 16-bit reads to a
// variable-latency instruction memory, with at most one read outstanding.
// Fetched instructions go to a registered output that feeds the IF/ID
// register. A one-entry pending buffer holds a response that returns while
// decode is stalled. A resteer from the branch controller flushes the output,
// the pending buffer and any in-flight response.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   rst               synchronous active-high reset
//   IF_rewrite_pc     resteer request, acted on in the same cycle
//   IF_pc_rewrite_to  resteer target
//   ID_stall          decode cannot accept the current output
//   IF_halt           level; blocks new requests only
//   imem_rd           request strobe, one cycle per request
//   imem_addr         request address
//   imem_rdata        read data, valid with imem_done
//   imem_done         one-cycle completion pulse
//   IF_valid          output holds a live instruction
//   IF_instr          fetched instruction, NOP_INSTR when IF_valid=0
//   IF_pc_plus2       fetch address + 2 of the output instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_rewrite_pc,
    input  logic [15:0] IF_pc_rewrite_to,
    input  logic        ID_stall,
    input  logic        IF_halt,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        IF_valid,
    output logic [15:0] IF_instr,
    output logic [15:0] IF_pc_plus2
);

    // IDLE: nothing outstanding; WAIT: outstanding, keep the data;
    // DRAIN: outstanding but on the wrong path, drop the data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] req_npc_reg;
    logic        valid_reg;
    logic [15:0] instr_reg;
    logic [15:0] npc_reg;
    logic        pend_valid_reg;
    logic [15:0] pend_instr_reg;
    logic [15:0] pend_npc_reg;

    logic        accept;
    logic        out_free;
    logic        deliver;
    logic        issue;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_reg + 16'd2;
    assign accept   = valid_reg && !ID_stall;
    assign out_free = !valid_reg || !ID_stall;
    assign deliver  = (state_reg == WAIT) && imem_done && !IF_rewrite_pc;

    // A new request can go out in the same cycle the previous one completes,
    // which gives one instruction per cycle with a single-cycle memory. The
    // pending-buffer check guarantees a later delivery always has somewhere
    // to land.
    assign issue = !rst && !IF_halt && !IF_rewrite_pc && !pend_valid_reg &&
                   ((state_reg == IDLE) ||
                    ((state_reg == WAIT) && imem_done && out_free));

    assign imem_rd     = issue;
    assign imem_addr   = pc_reg;
    assign IF_valid    = valid_reg;
    assign IF_instr    = valid_reg ? instr_reg : NOP_INSTR;
    assign IF_pc_plus2 = npc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            req_npc_reg    <= 16'h0000;
            valid_reg      <= 1'b0;
            instr_reg      <= NOP_INSTR;
            npc_reg        <= 16'h0000;
            pend_valid_reg <= 1'b0;
            pend_instr_reg <= NOP_INSTR;
            pend_npc_reg   <= 16'h0000;
        end else begin
            if (issue) begin
                pc_reg      <= pc_plus2;
                req_npc_reg <= pc_plus2;
            end

            if (IF_rewrite_pc) begin
                // Resteer flushes everything younger than the branch.
                pc_reg         <= IF_pc_rewrite_to;
                valid_reg      <= 1'b0;
                pend_valid_reg <= 1'b0;
            end else begin
                if (accept) begin
                    if (pend_valid_reg) begin
                        valid_reg      <= 1'b1;
                        instr_reg      <= pend_instr_reg;
                        npc_reg        <= pend_npc_reg;
                        pend_valid_reg <= 1'b0;
                    end else if (!deliver) begin
                        valid_reg <= 1'b0;
                    end
                end
                // A delivery never meets a full pending buffer: no request
                // is issued while the buffer holds an entry.
                if (deliver) begin
                    if (out_free && !pend_valid_reg) begin
                        valid_reg <= 1'b1;
                        instr_reg <= imem_rdata;
                        npc_reg   <= req_npc_reg;
                    end else begin
                        pend_valid_reg <= 1'b1;
                        pend_instr_reg <= imem_rdata;
                        pend_npc_reg   <= req_npc_reg;
                    end
                end
            end

            case (state_reg)
                IDLE: begin
                    if (issue) state_reg <= WAIT;
                end
                WAIT: begin
                    if (IF_rewrite_pc)
                        state_reg <= imem_done ? IDLE : DRAIN;
                    else if (imem_done)
                        state_reg <= issue ? WAIT : IDLE;
                end
                DRAIN: begin
                    if (imem_done) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A memory model answers each request after a fixed or
// random latency with a word derived from the address. A program-order model
// tracks the address the next issued request must use and the address of the
// next instruction decode must receive; a resteer moves both to the target.
// Directed tasks cover the cycle-level scenarios; a random task mixes stalls,
// halts and resteers.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IF_rewrite_pc = 1'b0;
    logic [15:0] IF_pc_rewrite_to = 16'h0000;
    logic        ID_stall = 1'b0;
    logic        IF_halt = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_done = 1'b0;
    logic        IF_valid;
    logic [15:0] IF_instr;
    logic [15:0] IF_pc_plus2;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .IF_rewrite_pc    (IF_rewrite_pc),
        .IF_pc_rewrite_to (IF_pc_rewrite_to),
        .ID_stall         (ID_stall),
        .IF_halt          (IF_halt),
        .imem_rd          (imem_rd),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_done        (imem_done),
        .IF_valid         (IF_valid),
        .IF_instr         (IF_instr),
        .IF_pc_plus2      (IF_pc_plus2)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_accept = 0;

    // Memory model state
    int          mem_lat = 1;      // 0 selects a random latency of 1..4
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_q = 16'h0000;

    // Program-order model
    logic [15:0] exp_issue = 16'h0000;
    logic [15:0] exp_deliver = 16'h0000;

    // Values observed in the most recent cycle
    logic        s_rd;
    logic [15:0] s_addr;
    logic        s_valid;
    logic [15:0] s_instr;
    logic [15:0] s_npc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0002: return 16'h2222;
            16'h0004: return 16'h3333;
            default:  return {a[7:0], a[15:8]} ^ 16'hB4C5;
        endcase
    endfunction

    // One clock cycle with the inputs currently driven.
    task automatic step();
        @(negedge clk);
        s_rd    = imem_rd;
        s_addr  = imem_addr;
        s_valid = IF_valid;
        s_instr = IF_instr;
        s_npc   = IF_pc_plus2;

        if (rst) begin
            exp_issue   = 16'h0000;
            exp_deliver = 16'h0000;
        end else begin
            if (!s_valid) begin
                n_total++;
                if (s_instr !== NOP) $display("FAIL sb_nop: IF_instr=%h want %h while invalid", s_instr, NOP);
                else n_pass++;
            end
            if (IF_rewrite_pc) begin
                n_total++;
                if (s_rd !== 1'b0) $display("FAIL sb_rd_on_rewrite: imem_rd=%b want 0", s_rd);
                else n_pass++;
                exp_issue   = IF_pc_rewrite_to;
                exp_deliver = IF_pc_rewrite_to;
            end else begin
                if (s_valid && !ID_stall) begin
                    n_accept++;
                    n_total++;
                    if (s_instr !== mem_word(exp_deliver))
                        $display("FAIL sb_instr: got %h want %h (addr %h)", s_instr, mem_word(exp_deliver), exp_deliver);
                    else n_pass++;
                    n_total++;
                    if (s_npc !== exp_deliver + 16'd2)
                        $display("FAIL sb_npc: got %h want %h", s_npc, exp_deliver + 16'd2);
                    else n_pass++;
                    exp_deliver = exp_deliver + 16'd2;
                end
                if (s_rd) begin
                    n_total++;
                    if (s_addr !== exp_issue) $display("FAIL sb_addr: got %h want %h", s_addr, exp_issue);
                    else n_pass++;
                    n_total++;
                    if (IF_halt || mem_busy)
                        $display("FAIL sb_issue_legal: imem_rd=1 with halt=%b outstanding=%b, want no request", IF_halt, mem_busy);
                    else n_pass++;
                    exp_issue = exp_issue + 16'd2;
                end
            end
        end

        if (s_rd) begin
            mem_busy = 1'b1;
            mem_q    = s_addr;
            mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        end

        @(posedge clk);
        #1;
        imem_done = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_done  = 1'b1;
                imem_rdata = mem_word(mem_q);
                mem_busy   = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        IF_rewrite_pc = 1'b0;
        ID_stall = 1'b0;
        IF_halt = 1'b0;
        mem_busy = 1'b0;
        imem_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until IF_valid is seen (bounded) and check the presented word.
    task automatic wait_valid(input string name, input logic [15:0] addr);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (s_valid) seen = 1;
        end
        n_total++;
        if (!seen) $display("FAIL %s_timeout: IF_valid never rose, want instr %h", name, mem_word(addr));
        else if (s_instr !== mem_word(addr) || s_npc !== addr + 16'd2)
            $display("FAIL %s_data: got %h/%h want %h/%h", name, s_instr, s_npc, mem_word(addr), addr + 16'd2);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_instr !== NOP || s_npc !== 16'h0000)
            $display("FAIL reset_state: rd=%b valid=%b instr=%h npc=%h want 0/0/%h/0000", s_rd, s_valid, s_instr, s_npc, NOP);
        else n_pass++;
        $display("test_reset: done");
    endtask

    task automatic test_stream();
        logic [15:0] exp_i [3] = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if (s_rd !== 1'b1 || s_addr !== 16'(2 * i))
                $display("FAIL stream_addr%0d: rd=%b addr=%h want 1/%h", i, s_rd, s_addr, 16'(2 * i));
            else n_pass++;
            if (i >= 2) begin
                n_total++;
                if (s_valid !== 1'b1 || s_instr !== exp_i[i-2] || s_npc !== 16'(2 * (i - 1)))
                    $display("FAIL stream_out%0d: %b/%h/%h want 1/%h/%h", i, s_valid, s_instr, s_npc, exp_i[i-2], 16'(2 * (i - 1)));
                else n_pass++;
            end
        end
        $display("test_stream: done");
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat = 1;
        step();
        step();
        ID_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (s_rd !== 1'b0 || s_valid !== 1'b1 || s_instr !== 16'h1111)
                $display("FAIL stall_hold%0d: rd=%b valid=%b instr=%h want 0/1/1111", i, s_rd, s_valid, s_instr);
            else n_pass++;
        end
        ID_stall = 1'b0;
        step();
        n_total++;
        if (s_rd !== 1'b0 || s_instr !== 16'h1111)
            $display("FAIL stall_release: rd=%b instr=%h want 0/1111", s_rd, s_instr);
        else n_pass++;
        step();
        n_total++;
        if (s_instr !== 16'h2222 || s_npc !== 16'h0004 || s_rd !== 1'b1 || s_addr !== 16'h0004)
            $display("FAIL stall_pend_out: instr=%h npc=%h rd=%b addr=%h want 2222/0004/1/0004", s_instr, s_npc, s_rd, s_addr);
        else n_pass++;
        step();
        n_total++;
        if (s_valid !== 1'b0) $display("FAIL stall_gap: valid=%b want 0", s_valid);
        else n_pass++;
        step();
        n_total++;
        if (s_instr !== 16'h3333 || s_npc !== 16'h0006)
            $display("FAIL stall_resume: instr=%h npc=%h want 3333/0006", s_instr, s_npc);
        else n_pass++;
        $display("test_stall: done");
    endtask

    task automatic test_drain();
        do_reset();
        mem_lat = 4;
        for (int i = 0; i < 5; i++) step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0002)
            $display("FAIL drain_issue2: rd=%b addr=%h want 1/0002", s_rd, s_addr);
        else n_pass++;
        IF_rewrite_pc = 1'b1;
        IF_pc_rewrite_to = 16'h0040;
        step();
        IF_rewrite_pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (s_rd !== 1'b0 || s_valid !== 1'b0)
                $display("FAIL drain_quiet%0d: rd=%b valid=%b want 0/0", i, s_rd, s_valid);
            else n_pass++;
        end
        step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0040)
            $display("FAIL drain_target: rd=%b addr=%h want 1/0040", s_rd, s_addr);
        else n_pass++;
        wait_valid("drain", 16'h0040);
        $display("test_drain: done");
    endtask

    task automatic test_rewrite_done();
        do_reset();
        mem_lat = 1;
        step();
        step();
        ID_stall = 1'b1;
        IF_rewrite_pc = 1'b1;
        IF_pc_rewrite_to = 16'h0100;
        step();
        n_total++;
        if (s_rd !== 1'b0) $display("FAIL rwdone_no_rd: rd=%b want 0", s_rd);
        else n_pass++;
        IF_rewrite_pc = 1'b0;
        ID_stall = 1'b0;
        step();
        n_total++;
        if (s_valid !== 1'b0 || s_rd !== 1'b1 || s_addr !== 16'h0100)
            $display("FAIL rwdone_next: valid=%b rd=%b addr=%h want 0/1/0100", s_valid, s_rd, s_addr);
        else n_pass++;
        wait_valid("rwdone", 16'h0100);
        $display("test_rewrite_done: done");
    endtask

    task automatic test_halt();
        int nvalid = 0;
        do_reset();
        mem_lat = 3;
        step();
        IF_halt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_total++;
            if (s_rd !== 1'b0) $display("FAIL halt_no_rd%0d: rd=%b want 0", i, s_rd);
            else n_pass++;
            if (s_valid) nvalid++;
        end
        n_total++;
        if (nvalid != 1) $display("FAIL halt_delivered: valid cycles=%0d want 1", nvalid);
        else n_pass++;
        IF_halt = 1'b0;
        step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0002)
            $display("FAIL halt_resume: rd=%b addr=%h want 1/0002", s_rd, s_addr);
        else n_pass++;
        $display("test_halt: done");
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat = 1;
        IF_rewrite_pc = 1'b1;
        IF_pc_rewrite_to = 16'hFFFE;
        step();
        IF_rewrite_pc = 1'b0;
        step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'hFFFE) $display("FAIL wrap_issue: rd=%b addr=%h want 1/fffe", s_rd, s_addr);
        else n_pass++;
        step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0000) $display("FAIL wrap_next: rd=%b addr=%h want 1/0000", s_rd, s_addr);
        else n_pass++;
        step();
        n_total++;
        if (s_valid !== 1'b1 || s_instr !== mem_word(16'hFFFE) || s_npc !== 16'h0000)
            $display("FAIL wrap_npc: %b/%h/%h want 1/%h/0000", s_valid, s_instr, s_npc, mem_word(16'hFFFE));
        else n_pass++;
        $display("test_wrap: done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) step();   // leave a valid output with npc != 0
        mem_lat = 4;
        ID_stall = 1'b1;
        step();
        rst = 1'b1;
        IF_halt = 1'b1;
        ID_stall = 1'b0;
        step();
        n_total++;
        if (s_rd !== 1'b0) $display("FAIL rstmid_rd: rd=%b want 0", s_rd);
        else n_pass++;
        rst = 1'b0;
        step();
        n_total++;
        if (s_valid !== 1'b0 || s_instr !== NOP || s_npc !== 16'h0000 || s_rd !== 1'b0)
            $display("FAIL rstmid_state: %b/%h/%h rd=%b want 0/%h/0000/0", s_valid, s_instr, s_npc, s_rd, NOP);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (s_valid !== 1'b0) $display("FAIL rstmid_late_done%0d: valid=%b want 0", i, s_valid);
            else n_pass++;
        end
        IF_halt = 1'b0;
        step();
        n_total++;
        if (s_rd !== 1'b1 || s_addr !== 16'h0000) $display("FAIL rstmid_restart: rd=%b addr=%h want 1/0000", s_rd, s_addr);
        else n_pass++;
        wait_valid("rstmid", 16'h0000);
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        int start_accept;
        do_reset();
        mem_lat = 0;
        start_accept = n_accept;
        for (int i = 0; i < 1500; i++) begin
            ID_stall = ($urandom_range(0, 99) < 30);
            IF_halt = ($urandom_range(0, 99) < 8);
            IF_rewrite_pc = ($urandom_range(0, 99) < 5);
            IF_pc_rewrite_to = ($urandom_range(0, 3) == 0) ? 16'hFFFA : (16'($urandom) & 16'hFFFE);
            step();
        end
        IF_rewrite_pc = 1'b0;
        n_total++;
        if (n_accept - start_accept < 100)
            $display("FAIL random_progress: accepted %0d want at least 100", n_accept - start_accept);
        else n_pass++;
        $display("test_random: %0d instructions accepted", n_accept - start_accept);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_rewrite_done();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
